// File: rtl/imem_arbiter.sv
// -----------------------------------------------------------------------------
// imem_arbiter
//
// Arbitrates a single-port instruction memory between the CPU fetch port and
// a debug port. Fetch normally wins, but a debug request that has waited
// MAX_WAIT consecutive cycles takes the next slot so debug cannot starve.
// A RUN/HALT state machine follows dbg_halt_i; in HALT only debug is served.
//
// Grants and the memory command are combinational from the inputs and the
// current state. The response (vld/err/data) follows its grant by exactly one
// cycle, which matches the one-cycle read latency of the external memory.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-low reset
//   fetch_req_i/addr_i    CPU fetch request and byte address
//   fetch_gnt_o           fetch accepted this cycle (combinational)
//   fetch_vld/err/data_o  fetch response, one cycle after grant
//   stall_o               fetch requested but not granted
//   dbg_req/we/addr/wdata debug access request
//   dbg_halt_i            level request to halt CPU fetch
//   dbg_gnt_o             debug accepted this cycle (combinational)
//   dbg_vld/err/rdata_o   debug response, one cycle after grant
//   halted_o              state machine is in HALT
//   mem_en/we/idx/wdata_o single-port memory command
//   mem_rdata_i           memory read data, valid the cycle after a read
// -----------------------------------------------------------------------------
module imem_arbiter #(
  parameter int DEPTH_WORDS = 32,
  parameter int MAX_WAIT    = 4,
  localparam int IDX_W      = $clog2(DEPTH_WORDS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  // CPU fetch port
  input  logic             fetch_req_i,
  input  logic [31:0]      fetch_addr_i,
  output logic             fetch_gnt_o,
  output logic             fetch_vld_o,
  output logic             fetch_err_o,
  output logic [31:0]      fetch_data_o,
  output logic             stall_o,
  // debug port
  input  logic             dbg_req_i,
  input  logic             dbg_we_i,
  input  logic [31:0]      dbg_addr_i,
  input  logic [31:0]      dbg_wdata_i,
  input  logic             dbg_halt_i,
  output logic             dbg_gnt_o,
  output logic             dbg_vld_o,
  output logic             dbg_err_o,
  output logic [31:0]      dbg_rdata_o,
  output logic             halted_o,
  // memory command
  output logic             mem_en_o,
  output logic             mem_we_o,
  output logic [IDX_W-1:0] mem_idx_o,
  output logic [31:0]      mem_wdata_o,
  input  logic [31:0]      mem_rdata_i
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t     state_q,     state_d;
  logic [3:0] wait_cnt_q,  wait_cnt_d;
  // response pipeline: *_rd_q marks a legal read whose data must be forwarded
  logic       fetch_vld_q, fetch_vld_d;
  logic       fetch_err_q, fetch_err_d;
  logic       fetch_rd_q,  fetch_rd_d;
  logic       dbg_vld_q,   dbg_vld_d;
  logic       dbg_err_q,   dbg_err_d;
  logic       dbg_rd_q,    dbg_rd_d;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  function automatic logic addr_legal(input logic [31:0] addr);
    return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < 32'(DEPTH_WORDS));
  endfunction

  logic fetch_ok;
  logic dbg_ok;

  assign fetch_ok = addr_legal(fetch_addr_i);
  assign dbg_ok   = addr_legal(dbg_addr_i);

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic halted;
  logic dbg_prio;
  logic fetch_gnt;
  logic dbg_gnt;

  assign halted   = (state_q == ST_HALT);
  assign dbg_prio = (wait_cnt_q == 4'(MAX_WAIT));

  // rst_i gates both grants so nothing is accepted while reset is held, even
  // though the grant path itself is purely combinational.
  assign fetch_gnt = rst_i && !halted && fetch_req_i && !(dbg_req_i && dbg_prio);
  // Debug takes any slot fetch did not take; this also guarantees the two
  // grants are mutually exclusive by construction.
  assign dbg_gnt   = rst_i && dbg_req_i && !fetch_gnt;

  assign fetch_gnt_o = fetch_gnt;
  assign dbg_gnt_o   = dbg_gnt;
  assign stall_o     = rst_i && fetch_req_i && !fetch_gnt;

  // ---------------------------------------------------------------------------
  // Memory command. Illegal accesses are granted (so they get an error
  // response) but never reach the memory.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_idx_o   = '0;
    mem_wdata_o = '0;
    if (fetch_gnt && fetch_ok) begin
      mem_en_o  = 1'b1;
      mem_idx_o = fetch_addr_i[IDX_W+1:2];
    end else if (dbg_gnt && dbg_ok) begin
      mem_en_o  = 1'b1;
      mem_we_o  = dbg_we_i;
      mem_idx_o = dbg_addr_i[IDX_W+1:2];
      if (dbg_we_i) begin
        mem_wdata_o = dbg_wdata_i;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // Both transitions are driven by the level of dbg_halt_i alone.
    state_d = dbg_halt_i ? ST_HALT : ST_RUN;

    wait_cnt_d = wait_cnt_q;
    if (dbg_gnt) begin
      wait_cnt_d = 4'd0;
    end else if (dbg_req_i && (wait_cnt_q < 4'(MAX_WAIT))) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end

    fetch_vld_d = fetch_gnt;
    fetch_err_d = fetch_gnt && !fetch_ok;
    fetch_rd_d  = fetch_gnt && fetch_ok;

    dbg_vld_d   = dbg_gnt;
    dbg_err_d   = dbg_gnt && !dbg_ok;
    dbg_rd_d    = dbg_gnt && dbg_ok && !dbg_we_i;
  end

  // ---------------------------------------------------------------------------
  // Registers. Asynchronous reset also drops any pending response, so no
  // vld can appear after reset is released.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= 4'd0;
      fetch_vld_q <= 1'b0;
      fetch_err_q <= 1'b0;
      fetch_rd_q  <= 1'b0;
      dbg_vld_q   <= 1'b0;
      dbg_err_q   <= 1'b0;
      dbg_rd_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      fetch_vld_q <= fetch_vld_d;
      fetch_err_q <= fetch_err_d;
      fetch_rd_q  <= fetch_rd_d;
      dbg_vld_q   <= dbg_vld_d;
      dbg_err_q   <= dbg_err_d;
      dbg_rd_q    <= dbg_rd_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Response outputs. Read data is forwarded straight from the memory in the
  // response cycle; writes and illegal accesses return zero.
  // ---------------------------------------------------------------------------
  assign halted_o     = (state_q == ST_HALT);
  assign fetch_vld_o  = fetch_vld_q;
  assign fetch_err_o  = fetch_err_q;
  assign fetch_data_o = fetch_rd_q ? mem_rdata_i : 32'd0;
  assign dbg_vld_o    = dbg_vld_q;
  assign dbg_err_o    = dbg_err_q;
  assign dbg_rdata_o  = dbg_rd_q ? mem_rdata_i : 32'd0;

endmodule

// File: tb/tb_imem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_imem_arbiter
//
// Directed bench for imem_arbiter with a simple one-cycle-latency memory
// model attached to the mem_* port. Memory contents after reset fill:
// word i = {4{i[7:0]}}, except word 2 = 0x20080005.
// -----------------------------------------------------------------------------
module tb_imem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        fetch_req_i;
  logic [31:0] fetch_addr_i;
  logic        fetch_gnt_o;
  logic        fetch_vld_o;
  logic        fetch_err_o;
  logic [31:0] fetch_data_o;
  logic        stall_o;
  logic        dbg_req_i;
  logic        dbg_we_i;
  logic [31:0] dbg_addr_i;
  logic [31:0] dbg_wdata_i;
  logic        dbg_halt_i;
  logic        dbg_gnt_o;
  logic        dbg_vld_o;
  logic        dbg_err_o;
  logic [31:0] dbg_rdata_o;
  logic        halted_o;
  logic        mem_en_o;
  logic        mem_we_o;
  logic [4:0]  mem_idx_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  imem_arbiter #(
    .DEPTH_WORDS (32),
    .MAX_WAIT    (4)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .fetch_req_i  (fetch_req_i),
    .fetch_addr_i (fetch_addr_i),
    .fetch_gnt_o  (fetch_gnt_o),
    .fetch_vld_o  (fetch_vld_o),
    .fetch_err_o  (fetch_err_o),
    .fetch_data_o (fetch_data_o),
    .stall_o      (stall_o),
    .dbg_req_i    (dbg_req_i),
    .dbg_we_i     (dbg_we_i),
    .dbg_addr_i   (dbg_addr_i),
    .dbg_wdata_i  (dbg_wdata_i),
    .dbg_halt_i   (dbg_halt_i),
    .dbg_gnt_o    (dbg_gnt_o),
    .dbg_vld_o    (dbg_vld_o),
    .dbg_err_o    (dbg_err_o),
    .dbg_rdata_o  (dbg_rdata_o),
    .halted_o     (halted_o),
    .mem_en_o     (mem_en_o),
    .mem_we_o     (mem_we_o),
    .mem_idx_o    (mem_idx_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i)
  );

  // Memory model: single port, registered read, refilled while reset is low.
  logic [31:0] mem [32];

  always @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < 32; i++) begin
        mem[i] <= (i == 2) ? 32'h2008_0005 : {4{i[7:0]}};
      end
      mem_rdata_i <= 32'd0;
    end else if (mem_en_o) begin
      if (mem_we_o) begin
        mem[mem_idx_o] <= mem_wdata_o;
      end else begin
        mem_rdata_i <= mem[mem_idx_o];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  logic exp_f;
  logic exp_d;
  logic exp_f_prev;
  logic exp_d_prev;

  initial begin
    rst_i        = 1'b0;
    fetch_req_i  = 1'b1;
    fetch_addr_i = 32'h8;
    dbg_req_i    = 1'b0;
    dbg_we_i     = 1'b0;
    dbg_addr_i   = 32'h0;
    dbg_wdata_i  = 32'h0;
    dbg_halt_i   = 1'b0;

    // ---------------- reset state (request already present) ----------------
    #2;
    check_eq("rst_fetch_gnt", 32'(fetch_gnt_o), 0);
    check_eq("rst_stall",     32'(stall_o),     0);
    check_eq("rst_mem_en",    32'(mem_en_o),    0);
    check_eq("rst_fetch_vld", 32'(fetch_vld_o), 0);
    check_eq("rst_halted",    32'(halted_o),    0);
    tick();
    tick();
    check_eq("rst_fetch_gnt_clk", 32'(fetch_gnt_o), 0);

    // ---------------- fetch only at 0x8 ----------------
    rst_i = 1'b1;
    settle();
    check_eq("fo_gnt",     32'(fetch_gnt_o), 1);
    check_eq("fo_stall",   32'(stall_o),     0);
    check_eq("fo_mem_en",  32'(mem_en_o),    1);
    check_eq("fo_mem_idx", 32'(mem_idx_o),   2);
    check_eq("fo_mem_we",  32'(mem_we_o),    0);
    check_eq("fo_dbg_gnt", 32'(dbg_gnt_o),   0);
    tick();
    fetch_req_i = 1'b0;
    settle();
    check_eq("fo_vld",  32'(fetch_vld_o), 1);
    check_eq("fo_data", fetch_data_o,     32'h2008_0005);
    check_eq("fo_err",  32'(fetch_err_o), 0);
    tick();
    settle();
    check_eq("fo_vld_once", 32'(fetch_vld_o), 0);

    // ---------------- starvation: both held, 4 fetch then 1 debug ----------------
    fetch_req_i  = 1'b1;
    fetch_addr_i = 32'h20;   // word 8
    dbg_req_i    = 1'b1;
    dbg_we_i     = 1'b0;
    dbg_addr_i   = 32'h4;    // word 1
    exp_f_prev   = 1'b0;
    exp_d_prev   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      settle();
      exp_d = ((i % 5) == 4);
      exp_f = !exp_d;
      check_eq($sformatf("sv_fetch_gnt[%0d]", i), 32'(fetch_gnt_o), 32'(exp_f));
      check_eq($sformatf("sv_dbg_gnt[%0d]", i),   32'(dbg_gnt_o),   32'(exp_d));
      check_eq($sformatf("sv_fetch_vld[%0d]", i), 32'(fetch_vld_o), 32'(exp_f_prev));
      check_eq($sformatf("sv_dbg_vld[%0d]", i),   32'(dbg_vld_o),   32'(exp_d_prev));
      if (exp_f_prev) begin
        check_eq($sformatf("sv_fetch_data[%0d]", i), fetch_data_o, 32'h0808_0808);
      end
      if (exp_d_prev) begin
        check_eq($sformatf("sv_dbg_rdata[%0d]", i), dbg_rdata_o, 32'h0101_0101);
      end
      tick();
      exp_f_prev = exp_f;
      exp_d_prev = exp_d;
    end
    fetch_req_i = 1'b0;
    dbg_req_i   = 1'b0;
    settle();
    check_eq("sv_last_dbg_vld",   32'(dbg_vld_o),   1);
    check_eq("sv_last_dbg_rdata", dbg_rdata_o,      32'h0101_0101);
    check_eq("sv_last_fetch_vld", 32'(fetch_vld_o), 0);

    // ---------------- halt, write, read, resume ----------------
    fetch_req_i  = 1'b1;
    fetch_addr_i = 32'h8;
    dbg_halt_i   = 1'b1;
    settle();
    check_eq("ht_gnt_before_halt", 32'(fetch_gnt_o), 1);
    tick();
    settle();
    check_eq("ht_halted",       32'(halted_o),    1);
    check_eq("ht_fetch_gnt",    32'(fetch_gnt_o), 0);
    check_eq("ht_stall",        32'(stall_o),     1);
    check_eq("ht_pending_vld",  32'(fetch_vld_o), 1);
    check_eq("ht_pending_data", fetch_data_o,     32'h2008_0005);
    dbg_req_i   = 1'b1;
    dbg_we_i    = 1'b1;
    dbg_addr_i  = 32'h10;
    dbg_wdata_i = 32'hDEAD_BEEF;
    settle();
    check_eq("hw_dbg_gnt",   32'(dbg_gnt_o),   1);
    check_eq("hw_mem_en",    32'(mem_en_o),    1);
    check_eq("hw_mem_we",    32'(mem_we_o),    1);
    check_eq("hw_mem_idx",   32'(mem_idx_o),   4);
    check_eq("hw_mem_wdata", mem_wdata_o,      32'hDEAD_BEEF);
    check_eq("hw_fetch_gnt", 32'(fetch_gnt_o), 0);
    tick();
    dbg_we_i = 1'b0;
    settle();
    check_eq("hw_wr_vld",   32'(dbg_vld_o), 1);
    check_eq("hw_wr_rdata", dbg_rdata_o,    32'h0);
    check_eq("hw_wr_err",   32'(dbg_err_o), 0);
    check_eq("hr_dbg_gnt",  32'(dbg_gnt_o), 1);
    check_eq("hr_mem_we",   32'(mem_we_o),  0);
    tick();
    dbg_req_i  = 1'b0;
    dbg_halt_i = 1'b0;
    settle();
    check_eq("hr_vld",          32'(dbg_vld_o),   1);
    check_eq("hr_rdata",        dbg_rdata_o,      32'hDEAD_BEEF);
    check_eq("hr_still_halted", 32'(halted_o),    1);
    check_eq("hr_no_fetch_gnt", 32'(fetch_gnt_o), 0);
    tick();
    settle();
    check_eq("rs_halted",    32'(halted_o),    0);
    check_eq("rs_fetch_gnt", 32'(fetch_gnt_o), 1);
    check_eq("rs_stall",     32'(stall_o),     0);

    // ---------------- illegal addresses ----------------
    tick();
    fetch_addr_i = 32'h6;
    settle();
    check_eq("rs_fetch_vld",  32'(fetch_vld_o), 1);
    check_eq("rs_fetch_data", fetch_data_o,     32'h2008_0005);
    check_eq("il_f_gnt",      32'(fetch_gnt_o), 1);
    check_eq("il_f_mem_en",   32'(mem_en_o),    0);
    tick();
    fetch_req_i = 1'b0;
    dbg_req_i   = 1'b1;
    dbg_we_i    = 1'b1;
    dbg_addr_i  = 32'h80;
    dbg_wdata_i = 32'h1234_5678;
    settle();
    check_eq("il_f_vld",    32'(fetch_vld_o), 1);
    check_eq("il_f_err",    32'(fetch_err_o), 1);
    check_eq("il_f_data",   fetch_data_o,     32'h0);
    check_eq("il_d_gnt",    32'(dbg_gnt_o),   1);
    check_eq("il_d_mem_en", 32'(mem_en_o),    0);
    tick();
    dbg_we_i   = 1'b0;
    dbg_addr_i = 32'h7C;   // last legal word
    settle();
    check_eq("il_d_vld",    32'(dbg_vld_o), 1);
    check_eq("il_d_err",    32'(dbg_err_o), 1);
    check_eq("il_d_rdata",  dbg_rdata_o,    32'h0);
    check_eq("bd_mem_en",   32'(mem_en_o),  1);
    check_eq("bd_mem_idx",  32'(mem_idx_o), 31);
    tick();
    dbg_req_i = 1'b0;
    settle();
    check_eq("bd_vld",        32'(dbg_vld_o), 1);
    check_eq("bd_err",        32'(dbg_err_o), 0);
    check_eq("bd_rdata",      dbg_rdata_o,    32'h1F1F_1F1F);
    check_eq("il_mem0_intact", mem[0],        32'h0);

    // ---------------- reset mid-operation ----------------
    tick();
    fetch_req_i  = 1'b1;
    fetch_addr_i = 32'h8;
    dbg_req_i    = 1'b1;
    dbg_addr_i   = 32'h4;
    settle();
    check_eq("rm_gnt0", 32'(fetch_gnt_o), 1);
    tick();
    settle();
    check_eq("rm_gnt1", 32'(fetch_gnt_o), 1);
    dbg_halt_i = 1'b1;
    tick();
    rst_i = 1'b0;
    settle();
    check_eq("rm_fetch_vld", 32'(fetch_vld_o),  0);
    check_eq("rm_dbg_vld",   32'(dbg_vld_o),    0);
    check_eq("rm_halted",    32'(halted_o),     0);
    check_eq("rm_fetch_gnt", 32'(fetch_gnt_o),  0);
    check_eq("rm_dbg_gnt",   32'(dbg_gnt_o),    0);
    check_eq("rm_stall",     32'(stall_o),      0);
    check_eq("rm_mem_en",    32'(mem_en_o),     0);
    check_eq("rm_fetch_data", fetch_data_o,     32'h0);
    dbg_halt_i = 1'b0;
    tick();
    settle();
    check_eq("rm_vld_in_rst", 32'(fetch_vld_o), 0);
    tick();
    rst_i = 1'b1;
    settle();
    check_eq("rr_fetch_vld", 32'(fetch_vld_o), 0);
    check_eq("rr_dbg_vld",   32'(dbg_vld_o),   0);
    check_eq("rr_halted",    32'(halted_o),    0);
    // wait count restarts from zero: four fetch grants before debug again
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        tick();
        settle();
      end
      check_eq($sformatf("rr_fetch_gnt[%0d]", i), 32'(fetch_gnt_o), 32'(i != 4));
      check_eq($sformatf("rr_dbg_gnt[%0d]", i),   32'(dbg_gnt_o),   32'(i == 4));
    end
    fetch_req_i = 1'b0;
    dbg_req_i   = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
